// File: rtl/mmio_host_bridge.sv
// mmio_host_bridge
// Byte-wide host register window in front of the control unit. The host
// loads CMD/ADDR/ARG/MMVR and rings DOORBELL. The bridge then pulses the
// control unit, follows its BUSY status and, for memory reads, captures
// the returned buffer into MMVR so the host can read it back.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   host_addr/wr_en/wdata       host byte write
//   host_rd_en                  host read strobe
//   host_rdata/host_rd_valid    registered read byte, valid one cycle after strobe
//   cmd_out/addr_out/arg_out/mmvr_out  command fields to the control unit
//   doorbell_pulse              one-cycle command trigger
//   status_in                   control unit status
//   rdata_in                    memory read data captured into MMVR
`ifndef HOST_DATA_WIDTH
`define HOST_DATA_WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef ARG_WIDTH
`define ARG_WIDTH 16
`endif
`ifndef BUFFER_WIDTH
`define BUFFER_WIDTH 256
`endif
`ifndef CMD_WRITE_MEM
`define CMD_WRITE_MEM 8'h01
`endif
`ifndef CMD_READ_MEM
`define CMD_READ_MEM 8'h02
`endif
`ifndef CMD_RUN
`define CMD_RUN 8'h03
`endif
`ifndef STATUS_IDLE
`define STATUS_IDLE 8'h00
`endif
`ifndef STATUS_BUSY
`define STATUS_BUSY 8'h01
`endif
`ifndef STATUS_HALTED
`define STATUS_HALTED 8'h02
`endif

module mmio_host_bridge #(
    parameter int HOST_DW = `HOST_DATA_WIDTH,
    parameter int ADDR_W  = `ADDR_WIDTH,
    parameter int ARG_W   = `ARG_WIDTH,
    parameter int BUF_W   = `BUFFER_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         host_addr,
    input  logic               host_wr_en,
    input  logic [7:0]         host_wdata,
    input  logic               host_rd_en,
    output logic [7:0]         host_rdata,
    output logic               host_rd_valid,
    output logic [HOST_DW-1:0] cmd_out,
    output logic [ADDR_W-1:0]  addr_out,
    output logic [ARG_W-1:0]   arg_out,
    output logic [BUF_W-1:0]   mmvr_out,
    output logic               doorbell_pulse,
    input  logic [HOST_DW-1:0] status_in,
    input  logic [BUF_W-1:0]   rdata_in
);

    localparam logic [1:0] BR_IDLE    = 2'd0;
    localparam logic [1:0] BR_ISSUED  = 2'd1;
    localparam logic [1:0] BR_RUNNING = 2'd2;
    localparam logic [1:0] BR_CAPTURE = 2'd3;

    localparam int NBYTES = BUF_W / 8;

    localparam logic [7:0] A_CMD      = 8'h00;
    localparam logic [7:0] A_STATUS   = 8'h01;
    localparam logic [7:0] A_ADDR_LO  = 8'h02;
    localparam logic [7:0] A_ADDR_HI  = 8'h03;
    localparam logic [7:0] A_ARG_LO   = 8'h04;
    localparam logic [7:0] A_ARG_HI   = 8'h05;
    localparam logic [7:0] A_DOORBELL = 8'h06;

    logic [1:0]         state_r;
    logic [1:0]         state_nx_s;
    logic [HOST_DW-1:0] cmd_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [ARG_W-1:0]   arg_r;
    logic [BUF_W-1:0]   mmvr_r;
    logic               is_read_r;
    logic               err_r;
    logic               doorbell_r;
    logic [7:0]         rdata_r;
    logic               rd_valid_r;

    logic               busy_s;
    logic               mmvr_hit_s;
    logic               cfg_hit_s;
    logic               wr_ok_s;
    logic               wr_rej_s;
    logic               db_go_s;
    logic [7:0]         rd_mux_s;
    logic [15:0]        addr_ext_s;
    logic [15:0]        arg_ext_s;
    logic               unused_status_s;

    assign busy_s          = (state_r != BR_IDLE);
    assign addr_ext_s      = 16'(addr_r);
    assign arg_ext_s       = 16'(arg_r);
    assign unused_status_s = ^status_in[HOST_DW-1:6];

    assign cmd_out        = cmd_r;
    assign addr_out       = addr_r;
    assign arg_out        = arg_r;
    assign mmvr_out       = mmvr_r;
    assign doorbell_pulse = doorbell_r;
    assign host_rdata     = rdata_r;
    assign host_rd_valid  = rd_valid_r;

    // Write decode: command-side registers are only writable while idle;
    // a write to them while a command is in flight is rejected and flagged.
    always_comb begin
        mmvr_hit_s = 1'b0;
        for (int i = 0; i < NBYTES; i++) begin
            mmvr_hit_s = mmvr_hit_s | (host_addr == 8'(32'd32 + i));
        end
        cfg_hit_s = (host_addr == A_CMD)     || (host_addr == A_ADDR_LO) ||
                    (host_addr == A_ADDR_HI) || (host_addr == A_ARG_LO)  ||
                    (host_addr == A_ARG_HI)  || (host_addr == A_DOORBELL) ||
                    mmvr_hit_s;
        wr_ok_s  = host_wr_en && cfg_hit_s && !busy_s;
        wr_rej_s = host_wr_en && cfg_hit_s && busy_s;
        db_go_s  = wr_ok_s && (host_addr == A_DOORBELL);
    end

    // Read mux over the current (pre-write) register contents.
    always_comb begin
        rd_mux_s = 8'h00;
        case (host_addr)
            A_CMD:      rd_mux_s = 8'(cmd_r);
            A_STATUS:   rd_mux_s = {busy_s, err_r, status_in[5:0]};
            A_ADDR_LO:  rd_mux_s = addr_ext_s[7:0];
            A_ADDR_HI:  rd_mux_s = addr_ext_s[15:8];
            A_ARG_LO:   rd_mux_s = arg_ext_s[7:0];
            A_ARG_HI:   rd_mux_s = arg_ext_s[15:8];
            A_DOORBELL: rd_mux_s = 8'h00;
            default: begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (host_addr == 8'(32'd32 + i)) begin
                        rd_mux_s = mmvr_r[8*i +: 8];
                    end else begin
                        rd_mux_s = rd_mux_s;
                    end
                end
            end
        endcase
    end

    // Command sequencer next state; ISSUED lets the control unit react to the pulse.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            BR_IDLE: begin
                if (db_go_s) state_nx_s = BR_ISSUED;
                else         state_nx_s = BR_IDLE;
            end
            BR_ISSUED: begin
                if (status_in == HOST_DW'(`STATUS_BUSY)) state_nx_s = BR_RUNNING;
                else                                     state_nx_s = BR_IDLE;
            end
            BR_RUNNING: begin
                if (status_in == HOST_DW'(`STATUS_BUSY)) state_nx_s = BR_RUNNING;
                else if (is_read_r)                      state_nx_s = BR_CAPTURE;
                else                                     state_nx_s = BR_IDLE;
            end
            BR_CAPTURE: state_nx_s = BR_IDLE;
            default:    state_nx_s = BR_IDLE;
        endcase
    end

    // Register file, sequencer state, error flag and host read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= BR_IDLE;
            cmd_r      <= '0;
            addr_r     <= '0;
            arg_r      <= '0;
            mmvr_r     <= '0;
            is_read_r  <= 1'b0;
            err_r      <= 1'b0;
            doorbell_r <= 1'b0;
            rdata_r    <= 8'h00;
            rd_valid_r <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            doorbell_r <= db_go_s;
            rd_valid_r <= host_rd_en;
            if (host_rd_en) begin
                rdata_r <= rd_mux_s;
            end
            if (db_go_s) begin
                is_read_r <= (cmd_r == HOST_DW'(`CMD_READ_MEM));
            end
            if (wr_rej_s) begin
                err_r <= 1'b1;
            end else if (host_wr_en && (host_addr == A_STATUS) && host_wdata[6]) begin
                err_r <= 1'b0;
            end
            if (wr_ok_s) begin
                case (host_addr)
                    A_CMD:      cmd_r  <= HOST_DW'(host_wdata);
                    A_ADDR_LO:  addr_r <= ADDR_W'({addr_ext_s[15:8], host_wdata});
                    A_ADDR_HI:  addr_r <= ADDR_W'({host_wdata, addr_ext_s[7:0]});
                    A_ARG_LO:   arg_r  <= ARG_W'({arg_ext_s[15:8], host_wdata});
                    A_ARG_HI:   arg_r  <= ARG_W'({host_wdata, arg_ext_s[7:0]});
                    A_DOORBELL: cmd_r  <= cmd_r;
                    default: begin
                        for (int i = 0; i < NBYTES; i++) begin
                            if (host_addr == 8'(32'd32 + i)) begin
                                mmvr_r[8*i +: 8] <= host_wdata;
                            end
                        end
                    end
                endcase
            end
            if (state_r == BR_CAPTURE) begin
                mmvr_r <= rdata_in;
            end
        end
    end

endmodule

// File: tb/tb_mmio_host_bridge.sv
// Testbench for mmio_host_bridge: randomized register traffic checked
// against a byte-map model, then directed command scenarios.
`ifndef CMD_WRITE_MEM
`define CMD_WRITE_MEM 8'h01
`endif
`ifndef CMD_READ_MEM
`define CMD_READ_MEM 8'h02
`endif
`ifndef CMD_RUN
`define CMD_RUN 8'h03
`endif
`ifndef STATUS_IDLE
`define STATUS_IDLE 8'h00
`endif
`ifndef STATUS_BUSY
`define STATUS_BUSY 8'h01
`endif
`ifndef STATUS_HALTED
`define STATUS_HALTED 8'h02
`endif

module tb_mmio_host_bridge;

    localparam int NB = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   host_addr = 8'h00;
    logic         host_wr_en = 1'b0;
    logic [7:0]   host_wdata = 8'h00;
    logic         host_rd_en = 1'b0;
    logic [7:0]   host_rdata;
    logic         host_rd_valid;
    logic [7:0]   cmd_out;
    logic [15:0]  addr_out;
    logic [15:0]  arg_out;
    logic [255:0] mmvr_out;
    logic         doorbell_pulse;
    logic [7:0]   status_in = `STATUS_IDLE;
    logic [255:0] rdata_in = '0;

    mmio_host_bridge dut (
        .clk(clk), .rst(rst),
        .host_addr(host_addr), .host_wr_en(host_wr_en), .host_wdata(host_wdata),
        .host_rd_en(host_rd_en), .host_rdata(host_rdata), .host_rd_valid(host_rd_valid),
        .cmd_out(cmd_out), .addr_out(addr_out), .arg_out(arg_out), .mmvr_out(mmvr_out),
        .doorbell_pulse(doorbell_pulse), .status_in(status_in), .rdata_in(rdata_in)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int pulse_cnt = 0;

    // Model: register byte map, bridge-idle flag and error flag.
    logic [7:0] reg_m [0:255];
    bit         idle_m = 1'b1;
    bit         err_m  = 1'b0;

    always @(negedge clk) if (doorbell_pulse === 1'b1) pulse_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit writable(input logic [7:0] a);
        return (a == 8'h00) || (a >= 8'h02 && a <= 8'h05) || (a >= 8'h20 && a < 8'h40);
    endfunction

    function automatic logic [7:0] model_rd(input logic [7:0] a);
        return writable(a) ? reg_m[a] : 8'h00;
    endfunction

    function automatic logic [255:0] exp_mmvr();
        logic [255:0] v;
        for (int i = 0; i < NB; i++) v[8*i +: 8] = reg_m[32 + i];
        return v;
    endfunction

    function automatic logic [7:0] exp_status(input bit busy, input logic [7:0] st);
        return {busy, err_m, st[5:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        host_addr = a; host_wdata = d; host_wr_en = 1'b1;
        tick();
        host_wr_en = 1'b0;
        if (idle_m && writable(a)) reg_m[a] = d;
        if (!idle_m && (writable(a) || a == 8'h06)) err_m = 1'b1;
        else if (a == 8'h01 && d[6]) err_m = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string tag);
        host_addr = a; host_rd_en = 1'b1;
        tick();
        host_rd_en = 1'b0;
        chk({tag, "_valid"}, host_rd_valid, 1'b1);
        chk(tag, host_rdata, exp);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 256; i++) reg_m[i] = 8'h00;
        err_m = 1'b0;
        idle_m = 1'b1;
    endtask

    task automatic capture_model(input logic [255:0] v);
        for (int i = 0; i < NB; i++) reg_m[32 + i] = v[8*i +: 8];
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom();
        return v;
    endfunction

    initial begin
        logic [7:0]   a, d, exp_r;
        logic         we, re;
        logic [255:0] cap;
        int           p0;

        clear_model();
        // Reset state
        rst = 1'b1;
        tick(); tick();
        chk("rst_cmd", cmd_out, 8'h00);
        chk("rst_addr", addr_out, 16'h0000);
        chk("rst_arg", arg_out, 16'h0000);
        chk("rst_mmvr", mmvr_out, 256'h0);
        chk("rst_pulse", doorbell_pulse, 1'b0);
        chk("rst_rdvalid", host_rd_valid, 1'b0);
        chk("rst_rdata", host_rdata, 8'h00);
        rst = 1'b0;
        tick();
        rd(8'h01, 8'h00, "rst_status");

        // Randomized register traffic while idle
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 5))
                0: a = 8'h00;
                1: a = 8'($urandom_range(2, 5));
                2, 3: a = 8'($urandom_range(32, 63));
                4: a = 8'($urandom_range(7, 31));
                default: a = 8'($urandom_range(64, 255));
            endcase
            d  = 8'($urandom());
            we = 1'($urandom());
            re = 1'($urandom());
            exp_r = model_rd(a);
            host_addr = a; host_wdata = d; host_wr_en = we; host_rd_en = re;
            tick();
            host_wr_en = 1'b0; host_rd_en = 1'b0;
            if (we && writable(a)) reg_m[a] = d;
            chk("rnd_valid", host_rd_valid, re);
            if (re) chk("rnd_rdata", host_rdata, exp_r);
            if (n % 25 == 24) begin
                chk("rnd_cmd", cmd_out, reg_m[0]);
                chk("rnd_addr", addr_out, {reg_m[3], reg_m[2]});
                chk("rnd_arg", arg_out, {reg_m[5], reg_m[4]});
                chk("rnd_mmvr", mmvr_out, exp_mmvr());
                chk("rnd_nopulse", doorbell_pulse, 1'b0);
            end
        end

        // Write-memory command
        wr(8'h02, 8'h10); wr(8'h03, 8'h00); wr(8'h20, 8'hAA); wr(8'h00, `CMD_WRITE_MEM);
        p0 = pulse_cnt;
        wr(8'h06, 8'h5A);
        idle_m = 1'b0;
        chk("wm_pulse_hi", doorbell_pulse, 1'b1);
        status_in = `STATUS_BUSY;
        tick();
        chk("wm_pulse_lo", doorbell_pulse, 1'b0);
        status_in = `STATUS_IDLE;
        tick();
        idle_m = 1'b1;
        chk("wm_pulse_cnt", pulse_cnt - p0, 1);
        chk("wm_addr", addr_out, 16'h0010);
        chk("wm_mmvr0", mmvr_out[7:0], 8'hAA);
        chk("wm_mmvr", mmvr_out, exp_mmvr());
        rd(8'h01, exp_status(1'b0, `STATUS_IDLE), "wm_status");

        // Read-memory command with capture
        wr(8'h00, `CMD_READ_MEM);
        p0 = pulse_cnt;
        wr(8'h06, 8'h00);
        idle_m = 1'b0;
        cap = rnd256();
        cap[7:0] = 8'h5C;
        rdata_in = cap;
        status_in = `STATUS_BUSY;
        tick();
        status_in = `STATUS_IDLE;
        tick();
        rd(8'h01, exp_status(1'b1, `STATUS_IDLE), "rm_capture_busy");
        capture_model(cap);
        idle_m = 1'b1;
        rdata_in = ~cap;
        rd(8'h20, 8'h5C, "rm_rd20");
        chk("rm_mmvr", mmvr_out, exp_mmvr());
        chk("rm_pulse_cnt", pulse_cnt - p0, 1);

        // Run command ending in HALTED: no capture
        wr(8'h00, `CMD_RUN); wr(8'h04, 8'h03); wr(8'h05, 8'h00);
        wr(8'h06, 8'h01);
        idle_m = 1'b0;
        rdata_in = rnd256();
        status_in = `STATUS_BUSY;
        repeat (9) tick();
        rd(8'h01, exp_status(1'b1, `STATUS_BUSY), "run_busy");
        status_in = `STATUS_HALTED;
        tick();
        idle_m = 1'b1;
        tick();
        chk("run_arg", arg_out, 16'h0003);
        chk("run_mmvr", mmvr_out, exp_mmvr());
        rd(8'h01, exp_status(1'b0, `STATUS_HALTED), "run_status");

        // Writes while running are rejected and flag err
        status_in = `STATUS_IDLE;
        wr(8'h00, `CMD_RUN);
        wr(8'h06, 8'h00);
        idle_m = 1'b0;
        status_in = `STATUS_BUSY;
        tick();
        p0 = pulse_cnt;
        wr(8'h06, 8'hFF);
        wr(8'h20, 8'h11);
        wr(8'h00, 8'h77);
        tick();
        chk("rej_pulse", pulse_cnt - p0, 0);
        chk("rej_mmvr", mmvr_out, exp_mmvr());
        chk("rej_cmd", cmd_out, reg_m[0]);
        rd(8'h01, exp_status(1'b1, `STATUS_BUSY), "rej_status_err");
        status_in = `STATUS_HALTED;
        tick();
        idle_m = 1'b1;
        wr(8'h01, 8'h40);
        rd(8'h01, exp_status(1'b0, `STATUS_HALTED), "rej_err_clr");

        // Doorbell while control unit stays HALTED
        p0 = pulse_cnt;
        wr(8'h06, 8'h00);
        rd(8'h01, exp_status(1'b1, `STATUS_HALTED), "halt_issued");
        rd(8'h01, exp_status(1'b0, `STATUS_HALTED), "halt_idle");
        chk("halt_pulse_cnt", pulse_cnt - p0, 1);
        chk("halt_mmvr", mmvr_out, exp_mmvr());

        // Doorbell on the capture-to-idle cycle is rejected
        status_in = `STATUS_IDLE;
        wr(8'h00, `CMD_READ_MEM);
        wr(8'h06, 8'h00);
        idle_m = 1'b0;
        cap = rnd256();
        rdata_in = cap;
        status_in = `STATUS_BUSY;
        tick();
        status_in = `STATUS_IDLE;
        tick();
        p0 = pulse_cnt;
        wr(8'h06, 8'h00);
        capture_model(cap);
        idle_m = 1'b1;
        tick();
        chk("capdb_pulse", pulse_cnt - p0, 0);
        chk("capdb_mmvr", mmvr_out, exp_mmvr());
        rd(8'h01, exp_status(1'b0, `STATUS_IDLE), "capdb_err");
        wr(8'h01, 8'h40);

        // Reset during a running read
        wr(8'h00, `CMD_READ_MEM);
        wr(8'h06, 8'h00);
        idle_m = 1'b0;
        status_in = `STATUS_BUSY;
        tick(); tick();
        rdata_in = rnd256() | 256'h1;
        rst = 1'b1;
        tick();
        clear_model();
        chk("mrst_pulse", doorbell_pulse, 1'b0);
        chk("mrst_mmvr", mmvr_out, 256'h0);
        status_in = `STATUS_IDLE;
        rst = 1'b0;
        p0 = pulse_cnt;
        tick(); tick(); tick();
        chk("mrst_cmd", cmd_out, 8'h00);
        chk("mrst_addr", addr_out, 16'h0000);
        chk("mrst_arg", arg_out, 16'h0000);
        chk("mrst_nocap", mmvr_out, 256'h0);
        chk("mrst_nopulse", pulse_cnt - p0, 0);
        rd(8'h7F, 8'h00, "mrst_unmapped");
        rd(8'h01, exp_status(1'b0, `STATUS_IDLE), "mrst_status");
        tick();
        chk("rdvalid_drop", host_rd_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
